// File: rtl/tcdm_conv_pkg.sv
// Shared types and helpers for the wide-to-narrow TCDM width converter.
package tcdm_conv_pkg;

  // Upper bound on beats per wide word that the beat-skip search handles.
  localparam int MAX_RATIO = 32;
  localparam int MAX_IDX_W = $clog2(MAX_RATIO);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } conv_state_e;

  typedef struct packed {
    logic                 valid;
    logic [MAX_IDX_W-1:0] idx;
  } beat_sel_t;

  // Number of narrow beats per wide word.
  function automatic int ratio_of(input int wide_dw, input int narrow_dw);
    return wide_dw / narrow_dw;
  endfunction

  // Bytes carried by one narrow beat.
  function automatic int beat_bytes_of(input int narrow_dw);
    return narrow_dw / 8;
  endfunction

  // Width of the beat index register, never narrower than one bit.
  function automatic int beat_idx_w_of(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

  // Lowest beat index >= first that must be issued. Reads issue every beat;
  // writes only issue beats whose byte-enable slice is nonzero (be_nz bit).
  function automatic beat_sel_t next_active_beat(input logic [MAX_RATIO-1:0] be_nz,
                                                 input int first,
                                                 input logic wen,
                                                 input int ratio);
    beat_sel_t sel;
    sel = '0;
    for (int i = MAX_RATIO - 1; i >= 0; i--) begin
      if (i >= first && i < ratio && (wen || be_nz[i])) begin
        sel.valid = 1'b1;
        sel.idx   = MAX_IDX_W'(i);
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/tcdm_width_converter.sv
// Wide-to-narrow TCDM bridge: splits one wide request into sequential narrow
// beats, skips write beats without enabled bytes, and reassembles the narrow
// responses into a single wide response with a sticky error flag.
module tcdm_width_converter
  import tcdm_conv_pkg::*;
#(
  parameter int WIDE_DW    = 64,
  parameter int NARROW_DW  = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    wide_req_i,
  input  logic [ADDR_WIDTH-1:0]   wide_add_i,
  input  logic                    wide_wen_i,
  input  logic [WIDE_DW-1:0]      wide_wdata_i,
  input  logic [WIDE_DW/8-1:0]    wide_be_i,
  output logic                    wide_gnt_o,
  output logic                    wide_r_valid_o,
  output logic [WIDE_DW-1:0]      wide_r_rdata_o,
  output logic                    wide_r_opc_o,
  output logic                    narrow_req_o,
  output logic [ADDR_WIDTH-1:0]   narrow_add_o,
  output logic                    narrow_wen_o,
  output logic [NARROW_DW-1:0]    narrow_wdata_o,
  output logic [NARROW_DW/8-1:0]  narrow_be_o,
  input  logic                    narrow_gnt_i,
  input  logic                    narrow_r_valid_i,
  input  logic [NARROW_DW-1:0]    narrow_r_rdata_i,
  input  logic                    narrow_r_opc_i
);

  localparam int RATIO      = ratio_of(WIDE_DW, NARROW_DW);
  localparam int BEAT_BYTES = beat_bytes_of(NARROW_DW);
  localparam int WIDE_BYTES = WIDE_DW / 8;
  localparam int BEAT_W     = beat_idx_w_of(RATIO);
  localparam int BB_SHIFT   = $clog2(BEAT_BYTES);

  // Reject width combinations the beat arithmetic cannot handle.
  if ((WIDE_DW % NARROW_DW) != 0) begin : g_bad_ratio
    $error("WIDE_DW must be a multiple of NARROW_DW");
  end
  if ((WIDE_DW & (WIDE_DW - 1)) != 0 || (NARROW_DW & (NARROW_DW - 1)) != 0) begin : g_bad_pow2
    $error("WIDE_DW and NARROW_DW must be powers of 2");
  end
  if (NARROW_DW < 8 || RATIO > MAX_RATIO) begin : g_bad_range
    $error("NARROW_DW must be >= 8 and WIDE_DW/NARROW_DW must not exceed MAX_RATIO");
  end

  conv_state_e               state_q, state_d;
  logic [BEAT_W-1:0]         beat_q, beat_d;
  logic [ADDR_WIDTH-1:0]     add_q;
  logic                      wen_q;
  logic [WIDE_DW-1:0]        wdata_q;
  logic [WIDE_BYTES-1:0]     be_q;
  logic [WIDE_DW-1:0]        rdata_q;
  logic                      opc_q;

  logic [MAX_RATIO-1:0]      be_nz_in, be_nz_q;
  beat_sel_t                 first_sel, next_sel;
  logic [NARROW_DW-1:0]      beat_wdata;
  logic [BEAT_BYTES-1:0]     beat_be;
  logic [NARROW_DW-1:0]      beat_mask;

  // Per-beat "any byte enabled" flags for the incoming and captured request.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    be_nz_in = '0;
    be_nz_q  = '0;
    for (int i = 0; i < RATIO; i++) begin
      be_nz_in[i] = |wide_be_i[i*BEAT_BYTES +: BEAT_BYTES];
      be_nz_q[i]  = |be_q[i*BEAT_BYTES +: BEAT_BYTES];
    end
  end

  // Slice of the captured request belonging to the current beat.
  always_comb begin
    beat_wdata = wdata_q[beat_q*NARROW_DW +: NARROW_DW];
    beat_be    = be_q[beat_q*BEAT_BYTES +: BEAT_BYTES];
    for (int b = 0; b < BEAT_BYTES; b++) begin
      beat_mask[b*8 +: 8] = {8{beat_be[b]}};
    end
  end

  // State and beat-index register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  // Next-state logic including the beat-skip search.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    first_sel = next_active_beat(be_nz_in, 0, wide_wen_i, RATIO);
    next_sel  = next_active_beat(be_nz_q, int'(beat_q) + 1, wen_q, RATIO);
    case (state_q)
      ST_IDLE: begin
        if (wide_req_i) begin
          if (first_sel.valid) begin
            beat_d  = first_sel.idx[BEAT_W-1:0];
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_ISSUE: begin
        if (narrow_gnt_i) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (narrow_r_valid_i) begin
          if (next_sel.valid) begin
            beat_d  = next_sel.idx[BEAT_W-1:0];
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Request capture and response reassembly.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      // NOTE: the data registers are reset too, because outputs must read 0 straight out of reset.
      add_q   <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      opc_q   <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && wide_req_i) begin
        add_q   <= wide_add_i & ~ADDR_WIDTH'(WIDE_BYTES - 1);
        wen_q   <= wide_wen_i;
        wdata_q <= wide_wdata_i;
        be_q    <= wide_be_i;
        rdata_q <= '0;
        opc_q   <= 1'b0;
      end else if (state_q == ST_WAIT && narrow_r_valid_i) begin
        // Disabled bytes of a read beat come back as zero.
        rdata_q[beat_q*NARROW_DW +: NARROW_DW] <= narrow_r_rdata_i & beat_mask;
        opc_q <= opc_q | narrow_r_opc_i;
      end
    end
  end

  // Output decode: everything is zero except in the state that owns it.
  always_comb begin
    wide_gnt_o     = 1'b0;
    wide_r_valid_o = 1'b0;
    wide_r_rdata_o = '0;
    wide_r_opc_o   = 1'b0;
    narrow_req_o   = 1'b0;
    narrow_add_o   = '0;
    narrow_wen_o   = 1'b0;
    narrow_wdata_o = '0;
    narrow_be_o    = '0;
    case (state_q)
      ST_IDLE: wide_gnt_o = wide_req_i;
      ST_ISSUE: begin
        narrow_req_o   = 1'b1;
        narrow_add_o   = add_q + (ADDR_WIDTH'(beat_q) << BB_SHIFT);
        narrow_wen_o   = wen_q;
        narrow_wdata_o = beat_wdata;
        narrow_be_o    = beat_be;
      end
      ST_RESP: begin
        wide_r_valid_o = 1'b1;
        wide_r_rdata_o = rdata_q;
        wide_r_opc_o   = opc_q;
      end
      default: ;
    endcase
  end

  // A narrow response is only legal while a beat is outstanding.
  a_rvalid_in_wait : assert property (@(posedge clk_i) disable iff (rst_i)
    narrow_r_valid_i |-> state_q == ST_WAIT);

endmodule

// File: tb/tb_tcdm_width_converter.sv
// Directed bench for tcdm_width_converter: a 64/32 and a 128/32 instance share
// one stimulus driver, one narrow-bank responder and one wide-response monitor.
module tb_tcdm_width_converter;

  typedef struct {
    logic [31:0] add;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          gnt_delay;
    int          resp_delay;
    logic [31:0] rdata;
    logic        opc;
  } narrow_exp_t;

  typedef struct {
    logic [127:0] rdata;
    logic         opc;
    logic         is_wr;
    int           lat;
  } wide_exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sel = 1'b0;   // 0: 64/32 instance, 1: 128/32 instance
  logic         req = 1'b0;
  logic [31:0]  add = '0;
  logic         wen = 1'b0;
  logic [127:0] wdata = '0;
  logic [15:0]  be = '0;
  logic         n_gnt = 1'b0, n_rvalid = 1'b0, n_opc = 1'b0;
  logic [31:0]  n_rdata = '0;

  logic         gnt64, rv64, opc64, nreq64, nwen64;
  logic [63:0]  rd64;
  logic [31:0]  nadd64, nwd64;
  logic [3:0]   nbe64;
  logic         gnt128, rv128, opc128, nreq128, nwen128;
  logic [127:0] rd128;
  logic [31:0]  nadd128, nwd128;
  logic [3:0]   nbe128;

  logic         m_gnt, m_rvalid, m_opc, m_req, m_wen;
  logic [127:0] m_rdata;
  logic [31:0]  m_add, m_wdata;
  logic [3:0]   m_be;

  narrow_exp_t  nq[$];
  wide_exp_t    wq[$];
  int           n_checks = 0;
  int           n_fail = 0;
  int           cyc = 0;
  int           gnt_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tcdm_width_converter #(.WIDE_DW(64), .NARROW_DW(32), .ADDR_WIDTH(32)) u_dut64 (
    .clk_i(clk), .rst_i(rst),
    .wide_req_i(req & ~sel), .wide_add_i(add), .wide_wen_i(wen),
    .wide_wdata_i(wdata[63:0]), .wide_be_i(be[7:0]), .wide_gnt_o(gnt64),
    .wide_r_valid_o(rv64), .wide_r_rdata_o(rd64), .wide_r_opc_o(opc64),
    .narrow_req_o(nreq64), .narrow_add_o(nadd64), .narrow_wen_o(nwen64),
    .narrow_wdata_o(nwd64), .narrow_be_o(nbe64),
    .narrow_gnt_i(n_gnt & ~sel), .narrow_r_valid_i(n_rvalid & ~sel),
    .narrow_r_rdata_i(n_rdata), .narrow_r_opc_i(n_opc)
  );

  tcdm_width_converter #(.WIDE_DW(128), .NARROW_DW(32), .ADDR_WIDTH(32)) u_dut128 (
    .clk_i(clk), .rst_i(rst),
    .wide_req_i(req & sel), .wide_add_i(add), .wide_wen_i(wen),
    .wide_wdata_i(wdata), .wide_be_i(be), .wide_gnt_o(gnt128),
    .wide_r_valid_o(rv128), .wide_r_rdata_o(rd128), .wide_r_opc_o(opc128),
    .narrow_req_o(nreq128), .narrow_add_o(nadd128), .narrow_wen_o(nwen128),
    .narrow_wdata_o(nwd128), .narrow_be_o(nbe128),
    .narrow_gnt_i(n_gnt & sel), .narrow_r_valid_i(n_rvalid & sel),
    .narrow_r_rdata_i(n_rdata), .narrow_r_opc_i(n_opc)
  );

  assign m_gnt    = sel ? gnt128  : gnt64;
  assign m_rvalid = sel ? rv128   : rv64;
  assign m_rdata  = sel ? rd128   : {64'b0, rd64};
  assign m_opc    = sel ? opc128  : opc64;
  assign m_req    = sel ? nreq128 : nreq64;
  assign m_add    = sel ? nadd128 : nadd64;
  assign m_wen    = sel ? nwen128 : nwen64;
  assign m_wdata  = sel ? nwd128  : nwd64;
  assign m_be     = sel ? nbe128  : nbe64;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_n(input logic [31:0] a, input logic w, input logic [31:0] d,
                        input logic [3:0] b, input int gd, input int rdl,
                        input logic [31:0] rd, input logic o);
    narrow_exp_t e;
    e.add = a; e.wen = w; e.wdata = d; e.be = b;
    e.gnt_delay = gd; e.resp_delay = rdl; e.rdata = rd; e.opc = o;
    nq.push_back(e);
  endtask

  // Issue one wide request, queue its expected response, optionally wait for it.
  task automatic send(input logic s, input logic [31:0] a, input logic w,
                      input logic [127:0] d, input logic [15:0] b,
                      input logic [127:0] exp_rd, input logic exp_opc,
                      input int lat, input bit wait_done);
    wide_exp_t e;
    bit granted = 0;
    @(posedge clk); #1;
    sel = s; req = 1'b1; add = a; wen = w; wdata = d; be = b;
    for (int i = 0; i < 50 && !granted; i++) begin
      #1;
      if (m_gnt) begin
        granted = 1;
        gnt_cyc = cyc;
        e.rdata = exp_rd; e.opc = exp_opc; e.is_wr = ~w; e.lat = lat;
        wq.push_back(e);
      end
      @(posedge clk); #1;
    end
    req = 1'b0;
    check("wide_gnt", granted, 1'b1);
    if (granted && wait_done) begin
      for (int i = 0; i < 200 && wq.size() != 0; i++) @(posedge clk);
      check("response_timeout", 128'(wq.size()), 128'd0);
      wq.delete();
    end
  endtask

  // Every output of the selected instance must be zero.
  task automatic check_zero(input string tag);
    check({tag, "_gnt"},    m_gnt, 1'b0);
    check({tag, "_rvalid"}, m_rvalid, 1'b0);
    check({tag, "_rdata"},  m_rdata, '0);
    check({tag, "_opc"},    m_opc, 1'b0);
    check({tag, "_nreq"},   m_req, 1'b0);
    check({tag, "_nadd"},   m_add, '0);
    check({tag, "_nwdata"}, {m_wen, m_be, m_wdata}, '0);
  endtask

  // Narrow bank model: checks each issued beat (every cycle it is held) and
  // answers with the scripted grant delay, response delay, data and error.
  initial begin
    narrow_exp_t e, cur;
    int wait_cnt = 0, resp_cnt = 0;
    bit pending = 0;
    forever begin
      @(posedge clk); #1;
      n_gnt = 1'b0; n_rvalid = 1'b0; n_rdata = '0; n_opc = 1'b0;
      if (rst) begin
        pending = 0; wait_cnt = 0; resp_cnt = 0;
      end else begin
        if (pending) begin
          if (resp_cnt == 0) begin
            n_rvalid = 1'b1; n_rdata = cur.rdata; n_opc = cur.opc; pending = 0;
          end else begin
            resp_cnt--;
          end
        end
        if (m_req) begin
          if (nq.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL narrow_unexpected_req: got add %h expected no request", m_add);
          end else begin
            e = nq[0];
            check("narrow_add", m_add, e.add);
            check("narrow_wen", m_wen, e.wen);
            check("narrow_be", m_be, e.be);
            if (!e.wen) check("narrow_wdata", m_wdata, e.wdata);
            if (wait_cnt == e.gnt_delay) begin
              n_gnt = 1'b1; cur = e; void'(nq.pop_front());
              pending = 1; resp_cnt = e.resp_delay; wait_cnt = 0;
            end else begin
              wait_cnt++;
            end
          end
        end
      end
    end
  end

  // Wide response monitor: pops the scoreboard whenever a response appears.
  initial begin
    wide_exp_t w;
    forever begin
      @(negedge clk);
      if (m_rvalid && !rst) begin
        if (wq.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL wide_unexpected_resp: got rdata %h opc %b expected no response", m_rdata, m_opc);
        end else begin
          w = wq.pop_front();
          if (!w.is_wr) check("wide_rdata", m_rdata, w.rdata);
          check("wide_opc", m_opc, w.opc);
          if (w.lat >= 0) check("wide_latency", 128'(cyc - gnt_cyc), 128'(w.lat));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state of both instances.
    repeat (3) @(posedge clk);
    @(negedge clk);
    sel = 1'b0; #1 check_zero("rst64");
    sel = 1'b1; #1 check_zero("rst128");
    sel = 1'b0;
    @(posedge clk); #1 rst = 1'b0;

    // Full 64-bit read.
    push_n(32'h1000, 1, 0, 4'hF, 0, 0, 32'hAAAA0001, 0);
    push_n(32'h1004, 1, 0, 4'hF, 0, 0, 32'hBBBB0002, 0);
    send(0, 32'h1000, 1, 0, 16'h00FF, 128'hBBBB0002AAAA0001, 0, 5, 1);

    // Upper-half write: only beat 1 issued.
    push_n(32'h200C, 0, 32'h11223344, 4'hF, 0, 0, 32'h0, 0);
    send(0, 32'h2008, 0, 128'h1122334455667788, 16'h00F0, '0, 0, 3, 1);

    // Empty write: no narrow traffic.
    send(0, 32'h2100, 0, 128'hDEADBEEF, 16'h0000, '0, 0, 1, 1);

    // Grant withheld 3 cycles on beat 0, error on beat 1.
    push_n(32'h3000, 1, 0, 4'hF, 3, 0, 32'h12345678, 0);
    push_n(32'h3004, 1, 0, 4'hF, 0, 0, 32'h9ABCDEF0, 1);
    send(0, 32'h3003, 1, 0, 16'h00FF, 128'h9ABCDEF012345678, 1, 8, 1);

    // Reset while waiting for a narrow response.
    push_n(32'h4000, 1, 0, 4'hF, 0, 5, 32'h55555555, 1);
    send(0, 32'h4000, 1, 0, 16'h00FF, '0, 0, -1, 0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check_zero("midrst");
    @(posedge clk); #1 rst = 1'b0;
    nq.delete(); wq.delete();

    // Fresh read after abort, then partial read with disabled beat 1 masked.
    push_n(32'h5000, 1, 0, 4'hF, 0, 0, 32'hCAFE0000, 0);
    push_n(32'h5004, 1, 0, 4'hF, 0, 0, 32'h0000BEEF, 0);
    send(0, 32'h5000, 1, 0, 16'h00FF, 128'h0000BEEFCAFE0000, 0, 5, 1);
    push_n(32'h5100, 1, 0, 4'h3, 0, 0, 32'h87654321, 0);
    push_n(32'h5104, 1, 0, 4'h0, 0, 0, 32'hFFFFFFFF, 0);
    send(0, 32'h5100, 1, 0, 16'h0003, 128'h0000000000004321, 0, 5, 1);

    // 128/32 read with be 0xF0F0: all four beats, disabled bytes return 0.
    push_n(32'h8000, 1, 0, 4'h0, 0, 0, 32'h11111111, 0);
    push_n(32'h8004, 1, 0, 4'hF, 0, 0, 32'h22222222, 0);
    push_n(32'h8008, 1, 0, 4'h0, 0, 0, 32'h33333333, 0);
    push_n(32'h800C, 1, 0, 4'hF, 0, 0, 32'h44444444, 0);
    send(1, 32'h8000, 1, 0, 16'hF0F0, 128'h44444444_00000000_22222222_00000000, 0, 9, 1);

    // 128/32 write with be 0xF0F0: beats 1 and 3 only, error on beat 3.
    push_n(32'h9014, 0, 32'h89ABCDEF, 4'hF, 0, 0, 32'h0, 0);
    push_n(32'h901C, 0, 32'h01234567, 4'hF, 1, 0, 32'h0, 1);
    send(1, 32'h9010, 0, 128'h01234567_76543210_89ABCDEF_FEDCBA98, 16'hF0F0, '0, 1, 6, 1);

    repeat (5) @(posedge clk);
    check("narrow_queue_drained", 128'(nq.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tcdm_width_converter.md
Name: tcdm_width_converter

Overview:
- Parametrised wide-to-narrow TCDM bridge. A WIDE_DW-bit master (e.g. a 64-bit DMA or accelerator port) reaches NARROW_DW-bit TCDM banks through it.
- Each accepted wide request becomes up to RATIO = WIDE_DW/NARROW_DW sequential narrow beats. Narrow responses are reassembled into one wide response.
- Sits between a 64-bit-capable master and the existing 32-bit cluster crossbar slave port.
- Adds byte-enable-driven beat skipping and sticky error merging.

Parameters:
- WIDE_DW, 64, wide data width; power of 2, multiple of NARROW_DW.
- NARROW_DW, 32, narrow data width; power of 2, >= 8.
- ADDR_WIDTH, 32, byte address width on both ports.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-high
- wide_req_i  in  1  wide request valid
- wide_add_i  in  ADDR_WIDTH  wide byte address
- wide_wen_i  in  1  1 = read, 0 = write (TCDM convention)
- wide_wdata_i  in  WIDE_DW  write data
- wide_be_i  in  WIDE_DW/8  byte enables
- wide_gnt_o  out  1  request accepted
- wide_r_valid_o  out  1  response valid
- wide_r_rdata_o  out  WIDE_DW  read data
- wide_r_opc_o  out  1  error flag
- narrow_req_o  out  1  narrow request
- narrow_add_o  out  ADDR_WIDTH  narrow byte address
- narrow_wen_o  out  1  read/write
- narrow_wdata_o  out  NARROW_DW  beat write data
- narrow_be_o  out  NARROW_DW/8  beat byte enables
- narrow_gnt_i  in  1  narrow grant
- narrow_r_valid_i  in  1  narrow response valid
- narrow_r_rdata_i  in  NARROW_DW  narrow read data
- narrow_r_opc_i  in  1  narrow error

Behaviour:
- Reset: state IDLE. All outputs 0, including rdata and opc. Beat counter and captured request registers cleared.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - wide_gnt_o = wide_req_i (combinational). On a grant, capture add, wen, wdata, be; clear the rdata buffer and sticky opc.
  - Beat set: reads use all RATIO beats. Writes use only beats whose be slice is nonzero.
  - Write with be == 0: go directly to RESP (no narrow traffic). Otherwise load the first active beat index and go to ISSUE.
- ISSUE:
  - narrow_req_o = 1.
  - narrow_add_o = {captured add with low log2(WIDE_DW/8) bits cleared} + beat*(NARROW_DW/8).
  - wdata and be are the beat's slice; wen is the captured value.
  - Outputs held stable until narrow_gnt_i. On grant go to WAIT.
- WAIT:
  - narrow_req_o = 0. On narrow_r_valid_i, write narrow_r_rdata_i into rdata slice [beat], and OR narrow_r_opc_i into the sticky opc.
  - If more active beats remain: advance to the next active index (skipping inactive beats) and go to ISSUE. Otherwise go to RESP.
- RESP: wide_r_valid_o = 1 for exactly one cycle, with the registered rdata and opc. Then go to IDLE.
- Inactive read bytes/beats return 0. Write responses carry undefined rdata; the bench checks only opc.
- Single outstanding wide transaction. wide_gnt_o is 0 outside IDLE.
- Minimum latency:
  - Full read, RATIO=2, zero-wait narrow side: gnt at cycle 0, wide_r_valid at cycle 5.
  - Empty write: wide_r_valid at cycle 1 after gnt.
- narrow_r_valid_i outside WAIT is a protocol violation. It is ignored and flagged by a simulation assertion.
- RATIO == 1 is legal: one beat, identical FSM.
- Elaboration error if WIDE_DW % NARROW_DW != 0 or either width is not a power of 2.
- rst_i asserted mid-transaction aborts immediately to IDLE. Narrow responses in flight are dropped; the narrow side shares the reset.

Decomposition:
- Package tcdm_conv_pkg:
  - FSM state enum.
  - Function next_active_beat(be, current, wen) returning index and a valid flag.
  - Localparam helpers RATIO, BEAT_BYTES, and the beat index width ($clog2(RATIO), minimum 1).
- No sub-module. The beat-skip priority search is a package function used in one always_comb.

Test Plan:
- 64/32 read at 0x1000, be=0xFF, banks return 0xAAAA0001 then 0xBBBB0002 -> narrow adds 0x1000, 0x1004; wide_r_rdata = 0xBBBB0002AAAA0001; opc=0.
- 64/32 write at 0x2008, be=0xF0, wdata=0x1122334455667788 -> exactly one narrow beat: add 0x200C, wdata 0x11223344, be 0xF; one wide_r_valid.
- Write with be=0x00 -> no narrow_req; wide_r_valid one cycle after gnt.
- Read where beat 1 returns r_opc=1 and narrow_gnt is withheld 3 cycles on beat 0 -> narrow request held stable for those cycles; wide_r_opc=1; response after all beats complete.
- rst_i pulsed while in WAIT -> all outputs 0 next edge. A new read afterwards completes normally with no stale rdata.
- WIDE_DW=128, NARROW_DW=32, read be=0xF0F0 -> all 4 beats issued at +0, +4, +8, +C. Repeat as a write -> only beats 1 and 3 issued.
